// File: rtl/flit_deserializer_pkg.sv
// rtl/flit_deserializer_pkg.sv - shared flit types, error bits and deserializer states
package flit_deserializer_pkg;

  localparam int FLIT_WIDTH = 128;
  localparam int FLIT_BYTES = FLIT_WIDTH / 8;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Error bits are OR-combined into one sticky word, so they are plain
  // one-hot constants rather than enum members.
  typedef logic [31:0] signal_t;
  localparam signal_t NO_ERROR           = 32'h0000_0000;
  localparam signal_t RX_BUFFER_OVERFLOW = 32'h0000_0001;
  localparam signal_t CHECKSUM_ERROR     = 32'h0000_0004;
  localparam signal_t RX_TIMEOUT         = 32'h0000_0008;

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_RECV = 1'b1
  } deser_state_t;

endpackage

// File: rtl/flit_deserializer_checksum_accum.sv
// rtl/flit_deserializer_checksum_accum.sv - 16-bit word checksum accumulator fed one byte at a time
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        zero the accumulator and held high byte (wins over byte_valid_i)
//   byte_valid_i   byte_i is valid this cycle
//   odd_i          byte_i is the low (odd-index) byte of a 16-bit word
//   byte_i         incoming byte
//   sum_o          accumulator plus {held high byte, byte_i}; on an odd byte this is
//                  the running word sum including the word completed this cycle
module checksum_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic        odd_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [7:0]  hi_q, hi_d;
  logic [15:0] acc_q, acc_d;

  // Carries out of bit 15 are dropped: mod-2^16 sum.
  assign sum_o = acc_q + {hi_q, byte_i};

  always_comb begin
    hi_d  = hi_q;
    acc_d = acc_q;
    if (clear_i) begin
      hi_d  = 8'h00;
      acc_d = 16'h0000;
    end else if (byte_valid_i) begin
      if (odd_i) acc_d = sum_o;
      else       hi_d  = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= 8'h00;
      acc_q <= 16'h0000;
    end else begin
      hi_q  <= hi_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/flit_deserializer.sv
// rtl/flit_deserializer.sv - assembles 16 UART bytes into a checksum-verified 128-bit flit
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rx_byte        byte from the UART RX stage, qualified by rx_valid (no backpressure)
//   flit_out       last good flit, stable while flit_valid is high
//   flit_valid     flit_out holds a flit not yet taken by downstream
//   flit_ready     downstream takes flit_out this cycle
//   error_status   sticky error bits (checksum, overflow, timeout)
//   error_clear    clear error_status; an error raised in the same cycle survives
//   busy           a partial flit is being assembled
module flit_deserializer
  import flit_deserializer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic [7:0] rx_byte,
  input  logic    rx_valid,
  output flit_t   flit_out,
  output logic    flit_valid,
  input  logic    flit_ready,
  output signal_t error_status,
  input  logic    error_clear,
  output logic    busy
);

  localparam int IW = $clog2(FLIT_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  deser_state_t   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  flit_t          asm_q, asm_d;
  flit_t          out_q, out_d;
  logic           valid_q, valid_d;
  signal_t        err_q, err_d;
  signal_t        new_err;

  logic           acc_clear;
  logic [15:0]    acc_sum;
  logic [6:0]     byte_base;
  flit_t          flit_full;

  checksum_accum u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (acc_clear),
    .byte_valid_i (rx_valid),
    .odd_i        (idx_q[0]),
    .byte_i       (rx_byte),
    .sum_o        (acc_sum)
  );

  // Byte k lands at bit (15-k)*8; for a 4-bit index 15-k is simply ~k.
  assign byte_base = {~idx_q, 3'b000};
  // The last byte is still on rx_byte when the flit completes.
  assign flit_full = {asm_q[FLIT_WIDTH-1:8], rx_byte};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    asm_d     = asm_q;
    out_d     = out_q;
    valid_d   = valid_q;
    new_err   = NO_ERROR;
    acc_clear = 1'b0;

    if (valid_q && flit_ready) valid_d = 1'b0;

    if (rx_valid) asm_d[byte_base +: 8] = rx_byte;

    case (state_q)
      DS_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          idx_d   = IW'(1);
          state_d = DS_RECV;
        end
      end
      DS_RECV: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (idx_q == IW'(FLIT_BYTES - 1)) begin
            idx_d     = '0;
            state_d   = DS_IDLE;
            acc_clear = 1'b1;
            // Checksum failure masks overflow; a slot being drained this
            // cycle counts as free.
            if (acc_sum != 16'h0000) begin
              new_err = CHECKSUM_ERROR;
            end else if (valid_q && !flit_ready) begin
              new_err = RX_BUFFER_OVERFLOW;
            end else begin
              out_d   = flit_full;
              valid_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d     = '0;
          idx_d     = '0;
          state_d   = DS_IDLE;
          acc_clear = 1'b1;
          new_err   = RX_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = DS_IDLE;
    endcase

    err_d = (error_clear ? NO_ERROR : err_q) | new_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DS_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= NO_ERROR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign flit_out     = out_q;
  assign flit_valid   = valid_q;
  assign error_status = err_q;
  assign busy         = (state_q == DS_RECV);

endmodule

// File: tb/tb_flit_deserializer.sv
// tb/tb_flit_deserializer.sv - self-checking bench for flit_deserializer
module tb_flit_deserializer;
  import flit_deserializer_pkg::*;

  localparam int TO = 50;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic    rx_valid = 1'b0;
  logic    flit_ready = 1'b0;
  logic    error_clear = 1'b0;
  flit_t   flit_out;
  logic    flit_valid;
  signal_t error_status;
  logic    busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  flit_deserializer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .flit_out     (flit_out),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .error_status (error_status),
    .error_clear  (error_clear),
    .busy         (busy)
  );

  typedef struct {
    flit_t   data;
    logic    good;
    signal_t err;
  } vec_t;

  typedef struct {
    logic       v;
    logic [7:0] b;
  } item_t;

  vec_t  tbl[8];
  item_t stim[$];

  // Reference model: bytes of the flit in progress, idle run length,
  // single output slot and sticky errors.
  logic [7:0] m_buf[$];
  int         m_idle;
  logic       m_ov;
  flit_t      m_od;
  signal_t    m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input flit_t d, input int lo, input int hi);
    flit_t t;
    for (int k = lo; k <= hi; k++) begin
      t = d << (8 * k);
      send_byte(t[127:120]);
    end
  endtask

  task automatic clear_err();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  function automatic logic [15:0] word_sum(input flit_t d);
    logic [15:0] s;
    flit_t t;
    s = 16'h0000;
    for (int w = 0; w < 8; w++) begin
      t = d << (16 * w);
      s = s + t[127:112];
    end
    return s;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_idle = 0;
    m_ov   = 1'b0;
    m_od   = '0;
    m_err  = NO_ERROR;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
    signal_t ne;
    logic    was_ov;
    flit_t   d;
    ne = NO_ERROR;
    was_ov = m_ov;
    if (m_ov && rdy) m_ov = 1'b0;
    if (v) begin
      m_buf.push_back(b);
      m_idle = 0;
      if (m_buf.size() == FLIT_BYTES) begin
        d = '0;
        foreach (m_buf[k]) d = {d[119:0], m_buf[k]};
        if (word_sum(d) != 16'h0000) ne = CHECKSUM_ERROR;
        else if (was_ov && !rdy) ne = RX_BUFFER_OVERFLOW;
        else begin
          m_ov = 1'b1;
          m_od = d;
        end
        m_buf.delete();
      end
    end else if (m_buf.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_buf.delete();
        m_idle = 0;
        ne = RX_TIMEOUT;
      end
    end
    m_err = (clr ? NO_ERROR : m_err) | ne;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flit_t last_good;
    logic [15:0] cs;
    logic [111:0] pay;
    int r;

    tbl[0] = '{128'h0001_0002_0003_0004_0005_0006_0007_FFE4, 1'b1, 32'h0};
    tbl[1] = '{128'h0001_0002_0003_0004_0005_0006_0007_FFE5, 1'b0, 32'h4};
    tbl[2] = '{128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 32'h0};
    tbl[3] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0007, 1'b1, 32'h0};
    tbl[4] = '{128'h1234_0000_0000_0000_0000_0000_0000_EDCC, 1'b1, 32'h0};
    tbl[5] = '{128'h1234_0000_0000_0000_0000_0000_0000_EDCD, 1'b0, 32'h4};
    tbl[6] = '{128'h8000_8000_8000_8000_8000_8000_8000_8000, 1'b1, 32'h0};
    tbl[7] = '{128'h0100_0000_0000_0000_0000_0000_0000_FF00, 1'b1, 32'h0};

    // Reset state
    tick();
    tick();
    chk("rst_valid", flit_valid, 1'b0);
    chk("rst_out", flit_out, '0);
    chk("rst_err", error_status, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table of whole flits with downstream always ready
    last_good = '0;
    flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clear_err();
      send_bytes(tbl[i].data, 0, 15);
      chk($sformatf("tbl%0d_valid", i), flit_valid, tbl[i].good);
      if (tbl[i].good) last_good = tbl[i].data;
      chk($sformatf("tbl%0d_out", i), flit_out, last_good);
      chk($sformatf("tbl%0d_err", i), error_status, tbl[i].err);
      chk($sformatf("tbl%0d_busy", i), busy, 1'b0);
      tick();
      chk($sformatf("tbl%0d_pop", i), flit_valid, 1'b0);
    end

    // Overflow: second good flit while the first is held
    clear_err();
    flit_ready = 1'b0;
    send_bytes(tbl[0].data, 0, 15);
    chk("ovf_first_valid", flit_valid, 1'b1);
    chk("ovf_first_out", flit_out, tbl[0].data);
    send_bytes(tbl[3].data, 0, 15);
    chk("ovf_hold_valid", flit_valid, 1'b1);
    chk("ovf_hold_out", flit_out, tbl[0].data);
    chk("ovf_err", error_status, 32'h1);
    flit_ready = 1'b1;
    tick();
    chk("ovf_pop_valid", flit_valid, 1'b0);
    chk("ovf_pop_out", flit_out, tbl[0].data);

    // Timeout after 5 bytes
    clear_err();
    send_bytes(tbl[6].data, 0, 4);
    chk("to_busy0", busy, 1'b1);
    repeat (TO - 1) tick();
    chk("to_busy_pre", busy, 1'b1);
    chk("to_err_pre", error_status, 32'h0);
    tick();
    chk("to_busy_post", busy, 1'b0);
    chk("to_err", error_status, 32'h8);
    clear_err();
    send_bytes(tbl[4].data, 0, 15);
    chk("to_next_valid", flit_valid, 1'b1);
    chk("to_next_out", flit_out, tbl[4].data);
    chk("to_next_err", error_status, 32'h0);
    tick();

    // Byte arriving exactly on the expiry cycle wins
    send_bytes(tbl[3].data, 0, 7);
    repeat (TO - 1) tick();
    chk("gap_busy", busy, 1'b1);
    send_bytes(tbl[3].data, 8, 15);
    chk("gap_valid", flit_valid, 1'b1);
    chk("gap_out", flit_out, tbl[3].data);
    chk("gap_err", error_status, 32'h0);
    tick();

    // Reset mid-flit with a pending output flit
    flit_ready = 1'b0;
    send_bytes(tbl[4].data, 0, 15);
    chk("mrst_pending", flit_valid, 1'b1);
    send_bytes(tbl[6].data, 0, 9);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", flit_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out", flit_out, '0);
    tick();
    rst_n = 1'b1;
    tick();
    flit_ready = 1'b1;
    send_bytes(tbl[7].data, 0, 15);
    chk("mrst_new_valid", flit_valid, 1'b1);
    chk("mrst_new_out", flit_out, tbl[7].data);
    chk("mrst_new_err", error_status, 32'h0);
    tick();
    chk("mrst_new_pop", flit_valid, 1'b0);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int f = 0; f < 60; f++) begin
      pay = {$urandom, $urandom, $urandom, 16'($urandom)};
      cs = 16'h0000;
      for (int w = 0; w < 7; w++) begin
        cs = cs + pay[111:96];
        pay = {pay[95:0], pay[111:96]};
      end
      cs = -cs;
      if ($urandom_range(0, 3) == 0) cs = cs ^ (16'h1 << $urandom_range(0, 15));
      for (int k = 0; k < 14; k++) begin
        stim.push_back('{1'b1, pay[111:104]});
        pay = {pay[103:0], pay[111:104]};
        r = $urandom_range(0, 99);
        if (r < 94) repeat ($urandom_range(0, 2)) stim.push_back('{1'b0, 8'h00});
        else if (r < 97) repeat (TO - 1) stim.push_back('{1'b0, 8'h00});
        else repeat (TO + $urandom_range(0, 3)) stim.push_back('{1'b0, 8'h00});
      end
      stim.push_back('{1'b1, cs[15:8]});
      stim.push_back('{1'b1, cs[7:0]});
      repeat ($urandom_range(0, 3)) stim.push_back('{1'b0, 8'h00});
    end
    foreach (stim[i]) begin
      rx_valid    = stim[i].v;
      rx_byte     = stim[i].b;
      flit_ready  = ($urandom_range(0, 3) != 0);
      error_clear = ($urandom_range(0, 19) == 0);
      model_step(rx_valid, rx_byte, flit_ready, error_clear);
      tick();
      chk("rand_ctl", {flit_valid, busy, error_status}, {m_ov, (m_buf.size() > 0), m_err});
      chk("rand_out", flit_out, m_od);
    end
    rx_valid = 1'b0;
    error_clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
